// File: rtl/tlb_ctrl.sv
// 16-entry joint TLB storage with TLBWI/TLBWR/TLBR/TLBP sequencing
// and the Wired/Random CP0 registers.
module tlb_ctrl #(
    parameter int unsigned NUM_ENTRIES = 16,
    parameter logic [3:0]  RANDOM_TOP  = 4'd15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    output logic        op_ready,
    input  logic [31:0] entry_hi,
    input  logic [31:0] entry_lo0,
    input  logic [31:0] entry_lo1,
    input  logic [3:0]  index_in,
    input  logic        wired_we,
    input  logic [3:0]  wired_in,
    output logic        result_valid,
    output logic [2:0]  result_op,
    output logic [31:0] rd_entry_hi,
    output logic [31:0] rd_entry_lo0,
    output logic [31:0] rd_entry_lo1,
    output logic [31:0] probe_index,
    output logic [3:0]  random_out,
    output logic [3:0]  wired_out,
    output logic [79:0] tlb_entry0,
    output logic [79:0] tlb_entry1,
    output logic [79:0] tlb_entry2,
    output logic [79:0] tlb_entry3,
    output logic [79:0] tlb_entry4,
    output logic [79:0] tlb_entry5,
    output logic [79:0] tlb_entry6,
    output logic [79:0] tlb_entry7,
    output logic [79:0] tlb_entry8,
    output logic [79:0] tlb_entry9,
    output logic [79:0] tlb_entry10,
    output logic [79:0] tlb_entry11,
    output logic [79:0] tlb_entry12,
    output logic [79:0] tlb_entry13,
    output logic [79:0] tlb_entry14,
    output logic [79:0] tlb_entry15
);

    typedef enum logic [2:0] {
        OP_TLBWI = 3'd1,
        OP_TLBWR = 3'd2,
        OP_TLBR  = 3'd3,
        OP_TLBP  = 3'd4
    } op_e;

    typedef enum logic {
        IDLE,
        PROBE
    } state_e;

    state_e      state_q;
    logic [79:0] entries_q [NUM_ENTRIES];
    logic        op_ready_q;
    logic        result_valid_q;
    logic [2:0]  result_op_q;
    logic [31:0] rd_entry_hi_q;
    logic [31:0] rd_entry_lo0_q;
    logic [31:0] rd_entry_lo1_q;
    logic [31:0] probe_index_q;
    logic [3:0]  random_q;
    logic [3:0]  wired_q;
    logic [18:0] probe_vpn2_q;
    logic [7:0]  probe_asid_q;

    logic        accept;
    logic [79:0] wr_entry;
    logic [79:0] rd_sel;
    logic        probe_hit;
    logic [3:0]  probe_hit_idx;
    logic        unused_bits;

    assign accept = op_valid && op_ready_q;

    assign wr_entry = {entry_hi[7:0], entry_lo0[0] & entry_lo1[0], entry_hi[31:13],
                       entry_lo1[29:6], entry_lo1[2], entry_lo1[1],
                       entry_lo0[29:6], entry_lo0[2], entry_lo0[1]};

    assign rd_sel = entries_q[index_in];

    assign unused_bits = ^{entry_hi[12:8], entry_lo0[31:30], entry_lo0[5:3],
                           entry_lo1[31:30], entry_lo1[5:3]};

    // Forward scan with a found flag so the lowest matching index wins.
    always_comb begin
        probe_hit     = 1'b0;
        probe_hit_idx = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (!probe_hit && entries_q[i][70:52] == probe_vpn2_q &&
                (entries_q[i][71] || entries_q[i][79:72] == probe_asid_q)) begin
                probe_hit     = 1'b1;
                probe_hit_idx = i[3:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                entries_q[i] <= '0;
            end
            op_ready_q     <= 1'b1;
            result_valid_q <= 1'b0;
            result_op_q    <= '0;
            rd_entry_hi_q  <= '0;
            rd_entry_lo0_q <= '0;
            rd_entry_lo1_q <= '0;
            probe_index_q  <= '0;
            random_q       <= RANDOM_TOP;
            wired_q        <= '0;
            probe_vpn2_q   <= '0;
            probe_asid_q   <= '0;
        end else begin
            result_valid_q <= 1'b0;

            // TLBWR below still indexes with the pre-update random_q.
            if (wired_we) begin
                wired_q  <= wired_in;
                random_q <= RANDOM_TOP;
            end else if (random_q <= wired_q) begin
                random_q <= RANDOM_TOP;
            end else begin
                random_q <= random_q - 4'd1;
            end

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        case (op_code)
                            OP_TLBWI: begin
                                entries_q[index_in] <= wr_entry;
                                result_valid_q      <= 1'b1;
                                result_op_q         <= op_code;
                            end
                            OP_TLBWR: begin
                                entries_q[random_q] <= wr_entry;
                                result_valid_q      <= 1'b1;
                                result_op_q         <= op_code;
                            end
                            OP_TLBR: begin
                                rd_entry_hi_q  <= {rd_sel[70:52], 5'b0, rd_sel[79:72]};
                                rd_entry_lo0_q <= {2'b0, rd_sel[25:2], 3'b0, rd_sel[1], rd_sel[0], rd_sel[71]};
                                rd_entry_lo1_q <= {2'b0, rd_sel[51:28], 3'b0, rd_sel[27], rd_sel[26], rd_sel[71]};
                                result_valid_q <= 1'b1;
                                result_op_q    <= op_code;
                            end
                            OP_TLBP: begin
                                probe_vpn2_q <= entry_hi[31:13];
                                probe_asid_q <= entry_hi[7:0];
                                op_ready_q   <= 1'b0;
                                state_q      <= PROBE;
                            end
                            default: ;
                        endcase
                    end
                end
                PROBE: begin
                    probe_index_q  <= probe_hit ? {28'b0, probe_hit_idx} : 32'h8000_0000;
                    result_valid_q <= 1'b1;
                    result_op_q    <= OP_TLBP;
                    op_ready_q     <= 1'b1;
                    state_q        <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign op_ready     = op_ready_q;
    assign result_valid = result_valid_q;
    assign result_op    = result_op_q;
    assign rd_entry_hi  = rd_entry_hi_q;
    assign rd_entry_lo0 = rd_entry_lo0_q;
    assign rd_entry_lo1 = rd_entry_lo1_q;
    assign probe_index  = probe_index_q;
    assign random_out   = random_q;
    assign wired_out    = wired_q;

    assign tlb_entry0  = entries_q[0];
    assign tlb_entry1  = entries_q[1];
    assign tlb_entry2  = entries_q[2];
    assign tlb_entry3  = entries_q[3];
    assign tlb_entry4  = entries_q[4];
    assign tlb_entry5  = entries_q[5];
    assign tlb_entry6  = entries_q[6];
    assign tlb_entry7  = entries_q[7];
    assign tlb_entry8  = entries_q[8];
    assign tlb_entry9  = entries_q[9];
    assign tlb_entry10 = entries_q[10];
    assign tlb_entry11 = entries_q[11];
    assign tlb_entry12 = entries_q[12];
    assign tlb_entry13 = entries_q[13];
    assign tlb_entry14 = entries_q[14];
    assign tlb_entry15 = entries_q[15];

endmodule

// File: tb/tb_tlb_ctrl.sv
// Bench for tlb_ctrl: table of write/readback vectors, scoreboard of
// expected results, and hand sequences for probe, Random and reset.
module tb_tlb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic [2:0]  op_code;
    logic        op_ready;
    logic [31:0] entry_hi, entry_lo0, entry_lo1;
    logic [3:0]  index_in;
    logic        wired_we;
    logic [3:0]  wired_in;
    logic        result_valid;
    logic [2:0]  result_op;
    logic [31:0] rd_entry_hi, rd_entry_lo0, rd_entry_lo1;
    logic [31:0] probe_index;
    logic [3:0]  random_out, wired_out;
    logic [79:0] ents [16];

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] hi, lo0, lo1, pidx;
    } exp_t;

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] hi, lo0, lo1;
        logic [79:0] exp_entry;
        logic [31:0] exp_hi, exp_lo0, exp_lo1;
    } vec_t;

    exp_t sb[$];
    exp_t cur;
    vec_t vec [4];

    tlb_ctrl #(.NUM_ENTRIES(16), .RANDOM_TOP(4'd15)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready),
        .entry_hi(entry_hi), .entry_lo0(entry_lo0), .entry_lo1(entry_lo1),
        .index_in(index_in), .wired_we(wired_we), .wired_in(wired_in),
        .result_valid(result_valid), .result_op(result_op),
        .rd_entry_hi(rd_entry_hi), .rd_entry_lo0(rd_entry_lo0), .rd_entry_lo1(rd_entry_lo1),
        .probe_index(probe_index), .random_out(random_out), .wired_out(wired_out),
        .tlb_entry0(ents[0]),   .tlb_entry1(ents[1]),   .tlb_entry2(ents[2]),   .tlb_entry3(ents[3]),
        .tlb_entry4(ents[4]),   .tlb_entry5(ents[5]),   .tlb_entry6(ents[6]),   .tlb_entry7(ents[7]),
        .tlb_entry8(ents[8]),   .tlb_entry9(ents[9]),   .tlb_entry10(ents[10]), .tlb_entry11(ents[11]),
        .tlb_entry12(ents[12]), .tlb_entry13(ents[13]), .tlb_entry14(ents[14]), .tlb_entry15(ents[15])
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] op, input logic [31:0] hi, input logic [31:0] lo0,
                                input logic [31:0] lo1, input logic [31:0] pidx);
        exp_t e;
        e.op = op; e.hi = hi; e.lo0 = lo0; e.lo1 = lo1; e.pidx = pidx;
        return e;
    endfunction

    // Drive at a falling edge; the op is accepted at the following rising edge.
    task automatic issue(input logic [2:0] op, input logic [3:0] idx, input logic [31:0] hi,
                         input logic [31:0] lo0, input logic [31:0] lo1);
        op_valid  = 1'b1;
        op_code   = op;
        index_in  = idx;
        entry_hi  = hi;
        entry_lo0 = lo0;
        entry_lo1 = lo1;
        @(negedge clk);
        op_valid  = 1'b0;
    endtask

    task automatic probe(input logic [31:0] hi, input logic [31:0] exp_pidx);
        sb.push_back(mk(3'd4, '0, '0, '0, exp_pidx));
        issue(3'd4, 4'd0, hi, '0, '0);
        check("probe_busy_ready", op_ready, 1'b0);
        @(negedge clk);
        check("probe_done_ready", op_ready, 1'b1);
    endtask

    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_result: got result_op %0d expected no result", result_op);
            end else begin
                cur = sb.pop_front();
                check("result_op", result_op, cur.op);
                if (cur.op == 3'd3) begin
                    check("rd_entry_hi", rd_entry_hi, cur.hi);
                    check("rd_entry_lo0", rd_entry_lo0, cur.lo0);
                    check("rd_entry_lo1", rd_entry_lo1, cur.lo1);
                end
                if (cur.op == 3'd4) check("probe_index", probe_index, cur.pidx);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rnd_exp [6];
        rnd_exp = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd15, 4'd14};

        vec[0] = '{4'd5, 32'h0040_2012, 32'h0000_1047, 32'h0000_1086,
                   {8'h12, 1'b0, 19'h00201, 24'h000042, 1'b1, 1'b1, 24'h000041, 1'b1, 1'b1},
                   32'h0040_2012, 32'h0000_1046, 32'h0000_1086};
        vec[1] = '{4'd9, 32'h0040_2012, 32'h0000_2043, 32'h0000_2085,
                   {8'h12, 1'b1, 19'h00201, 24'h000082, 1'b1, 1'b0, 24'h000081, 1'b0, 1'b1},
                   32'h0040_2012, 32'h0000_2043, 32'h0000_2085};
        vec[2] = '{4'd0, 32'hFFFF_FFAB, 32'hFFFF_FFFF, 32'hC000_003C,
                   {8'hAB, 1'b0, 19'h7FFFF, 24'h000000, 1'b1, 1'b0, 24'hFFFFFF, 1'b1, 1'b1},
                   32'hFFFF_E0AB, 32'h3FFF_FFC6, 32'h0000_0004};
        vec[3] = '{4'd15, 32'h1234_5677, 32'h0000_0001, 32'h0000_0001,
                   {8'h77, 1'b1, 19'h091A2, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0},
                   32'h1234_4077, 32'h0000_0001, 32'h0000_0001};

        rst_n = 1'b0; op_valid = 1'b0; op_code = '0; index_in = '0;
        entry_hi = '0; entry_lo0 = '0; entry_lo1 = '0; wired_we = 1'b0; wired_in = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 16; i++) check("reset_entry", ents[i], '0);
        check("reset_random", random_out, 4'd15);
        check("reset_wired", wired_out, 4'd0);
        check("reset_op_ready", op_ready, 1'b1);
        check("reset_result_valid", result_valid, 1'b0);
        check("reset_probe_index", probe_index, '0);
        check("reset_rd_hi", rd_entry_hi, '0);
        rst_n = 1'b1;

        // TLBWI then back-to-back TLBR of the same index
        for (int i = 0; i < 4; i++) begin
            sb.push_back(mk(3'd1, '0, '0, '0, '0));
            issue(3'd1, vec[i].idx, vec[i].hi, vec[i].lo0, vec[i].lo1);
            check("tlbwi_entry", ents[vec[i].idx], vec[i].exp_entry);
            sb.push_back(mk(3'd3, vec[i].exp_hi, vec[i].exp_lo0, vec[i].exp_lo1, '0));
            issue(3'd3, vec[i].idx, 32'hDEAD_BEEF, 32'h5555_5555, 32'hAAAA_AAAA);
            check("ready_after_tlbr", op_ready, 1'b1);
        end

        probe(32'h0040_2012, 32'h0000_0005);
        probe(32'h0040_2033, 32'h0000_0009);
        probe(32'h0000_0000, 32'h0000_0001);
        probe(32'h1234_4055, 32'h0000_000F);

        // Clear G on entry 15, then probe immediately with a foreign ASID
        sb.push_back(mk(3'd1, '0, '0, '0, '0));
        issue(3'd1, 4'd15, 32'h1234_4077, 32'h0000_0001, 32'h0000_0000);
        check("tlbwi_g_clear", ents[15], {8'h77, 1'b0, 19'h091A2, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0});
        probe(32'h1234_4055, 32'h8000_0000);
        probe(32'h1234_4077, 32'h0000_000F);

        issue(3'd0, 4'd3, 32'h1111_1111, '0, '0);
        issue(3'd5, 4'd3, 32'h1111_1111, '0, '0);
        issue(3'd7, 4'd3, 32'h1111_1111, '0, '0);
        check("nop_entry3", ents[3], '0);
        repeat (2) @(negedge clk);

        wired_we = 1'b1; wired_in = 4'd12;
        @(negedge clk);
        wired_we = 1'b0;
        check("wired_12", wired_out, 4'd12);
        for (int k = 0; k < 6; k++) begin
            check("random_seq", random_out, rnd_exp[k]);
            if (k == 2) begin
                sb.push_back(mk(3'd2, '0, '0, '0, '0));
                op_valid = 1'b1; op_code = 3'd2;
                entry_hi = vec[0].hi; entry_lo0 = vec[0].lo0; entry_lo1 = vec[0].lo1;
            end
            if (k == 3) begin
                op_valid = 1'b0;
                check("tlbwr_entry13", ents[13], vec[0].exp_entry);
            end
            @(negedge clk);
        end
        check("random_13", random_out, 4'd13);
        @(negedge clk);
        check("random_12", random_out, 4'd12);

        // Wired write and TLBWR on the same edge
        sb.push_back(mk(3'd2, '0, '0, '0, '0));
        wired_we = 1'b1; wired_in = 4'd15;
        op_valid = 1'b1; op_code = 3'd2;
        entry_hi = vec[2].hi; entry_lo0 = vec[2].lo0; entry_lo1 = vec[2].lo1;
        @(negedge clk);
        wired_we = 1'b0; op_valid = 1'b0;
        check("tlbwr_pre_random", ents[12], vec[2].exp_entry);
        check("random_forced", random_out, 4'd15);
        check("wired_15", wired_out, 4'd15);
        repeat (2) begin
            @(negedge clk);
            check("random_hold", random_out, 4'd15);
        end

        // Reset while in PROBE: no result, state cleared
        issue(3'd4, 4'd0, 32'h0040_2012, '0, '0);
        check("probe_busy_before_reset", op_ready, 1'b0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) check("midprobe_reset_entry", ents[i], '0);
        check("midprobe_reset_ready", op_ready, 1'b1);
        check("midprobe_reset_valid", result_valid, 1'b0);
        check("midprobe_reset_random", random_out, 4'd15);
        check("midprobe_reset_wired", wired_out, 4'd0);
        check("midprobe_reset_pidx", probe_index, '0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
